exc_sequencer: RTL
==================

Name: exc_sequencer

Overview:
- Initiator side of the CP0 exception interface in the multicycle MIPS54 core.
- Collects synchronous trap requests (syscall, break, teq), eret and the external interrupt, and prioritises them.
- Drives the CP0 exception/eret/cause/pc strobes as a fixed-length sequence, then loads PC from the CP0 exc_addr.
- Sits between the main control FSM and CP0/PC, and stalls the control FSM while a sequence runs.

Parameters:
- RESET_PC, 32'h00400000, value driven on pc_next while idle and after reset.
- INT_EN_BIT, 0, status bit index that, together with status[0], gates external interrupt acceptance.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- insn_boundary  in  1  control FSM is in its fetch state; the previous instruction has retired
- syscall_req  in  1  one-cycle pulse from execute
- break_req  in  1  one-cycle pulse from execute
- teq_req  in  1  one-cycle pulse from execute, asserted only when the trap condition is true
- eret_req  in  1  one-cycle pulse from execute
- ext_intr  in  1  level interrupt from a peripheral, asynchronous to clk
- cur_pc  in  32  PC.pc_out, address of the instruction currently executing
- cp0_status  in  32  CP0 status output
- cp0_exc_addr  in  32  CP0 exc_addr output
- cp0_exception  out  1  exception strobe to CP0
- cp0_eret  out  1  eret strobe to CP0
- cp0_cause  out  5  cause code to CP0
- cp0_pc  out  32  EPC candidate to CP0
- pc_load  out  1  PC write enable override
- pc_next  out  32  PC value when pc_load=1
- stall  out  1  freeze the control FSM

Behaviour:
- Cause codes: SYSCALL=5'b01000, BREAK=5'b01001, TEQ=5'b01101, INTR=5'b00000.
- States: IDLE, RAISE, ERET_ST, REDIRECT.
- IDLE, sync trap: any of syscall_req/break_req/teq_req seen. Latch cause and cur_pc into registers, go to RAISE. Priority: syscall > break > teq > eret.
- IDLE, eret: eret_req with no trap request. Go to ERET_ST.
- IDLE, interrupt: accepted only when all of these hold: insn_boundary=1, no other request, synced interrupt=1, cp0_status[0]=1, cp0_status[INT_EN_BIT]=1. Latch INTR and cur_pc, go to RAISE.
- RAISE (1 cycle): cp0_exception=1, cp0_cause and cp0_pc from the latched registers. Go to REDIRECT.
- ERET_ST (1 cycle): cp0_eret=1. Go to REDIRECT.
- REDIRECT (1 cycle): pc_load=1, pc_next=cp0_exc_addr. CP0 updated exc_addr on the edge that ended RAISE/ERET_ST, so the value is valid here. Go to IDLE.
- Latency: request pulse to pc_load is 3 cycles (accept, strobe, redirect).
- stall: combinational. stall = (state != IDLE) | any request in IDLE. The control FSM therefore never advances past a trapping instruction.
- Registered strobes: cp0_exception, cp0_eret and pc_load are registered state decodes, glitch-free, and each high exactly one cycle per sequence.
- Requests outside IDLE: sync and eret requests are ignored; the stalled control FSM cannot legally produce them, and this is checked by an assertion. ext_intr is level, so it is simply re-evaluated on return to IDLE.
- CP0 masks the trap (status[0]=0): the sequence is unchanged. CP0 returns exc_addr=pc, and the REDIRECT re-loads cur_pc.
- Reset (any state, including mid-sequence): state=IDLE; all strobes 0; cp0_cause=0; cp0_pc=0; pc_next=RESET_PC; synchroniser flops cleared. An in-flight sequence is dropped with no CP0 strobe.

Optional Feature:
- Macro: EXC_SEQ_INTR_EN.
- Defined: ext_intr passes through a 2-flop synchroniser, then the acceptance rules above apply.
- Undefined: no synchroniser flops, ext_intr is unused, and the interrupt path is never taken. Sync traps and eret are unchanged.

Decomposition:
- Shared package exc_pkg holds: 5-bit cause constants (SYSCALL, BREAK, TEQ, INTR); 2-bit state encoding typedef; RESET_PC default. CP0 and the control FSM reuse these.
- One natural sub-module, exc_sync2: 2-flop synchroniser with synchronous reset, instantiated only under EXC_SEQ_INTR_EN.

Test Plan:
- Reset mid-RAISE -> next cycle: state IDLE, cp0_exception=0, pc_next=32'h00400000, no pc_load.
- syscall_req pulse, cur_pc=32'h00400020, status=32'hF -> cycle+1: cp0_exception=1, cause=5'b01000, cp0_pc=32'h00400020. Cycle+2: pc_load=1, pc_next=32'h00400004. stall high for 3 cycles.
- syscall_req and break_req in the same cycle -> cause=5'b01000; break dropped.
- eret_req with CP0 EPC=32'h00400020 -> cycle+1: cp0_eret=1. Cycle+2: pc_load=1, pc_next=32'h00400020.
- EXC_SEQ_INTR_EN defined:
  - ext_intr held high, status=32'h1 (INT_EN_BIT=0), insn_boundary pulse at cycle 5 -> RAISE with cause=5'b00000 at cycle 6.
  - Same stimulus with status=32'h0 -> no sequence, stall=0.
  - Same stimulus with the macro undefined -> no sequence.
- teq_req pulse with status=32'h6 (status[0]=0, so CP0 masks) -> REDIRECT drives pc_next=cur_pc.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception sequencer: cause codes, state encoding, reset PC.
package exc_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 5;

    typedef logic [CAUSE_W-1:0] cause_t;

    localparam cause_t CAUSE_SYSCALL = 5'b01000;
    localparam cause_t CAUSE_BREAK   = 5'b01001;
    localparam cause_t CAUSE_TEQ     = 5'b01101;
    localparam cause_t CAUSE_INTR    = 5'b00000;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAISE    = 2'd1,
        ST_ERET     = 2'd2,
        ST_REDIRECT = 2'd3
    } exc_state_t;

    // Latched exception record presented to CP0 during RAISE
    typedef struct packed {
        cause_t          cause;
        logic [XLEN-1:0] pc;
    } exc_rec_t;

    // Synchronous trap priority: syscall > break > teq
    function automatic cause_t pick_cause(input logic syscall, input logic brk);
        if (syscall)
            return CAUSE_SYSCALL;
        else if (brk)
            return CAUSE_BREAK;
        return CAUSE_TEQ;
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Exception request / CP0 strobe bundle between control FSM, CP0, PC and the sequencer.
interface exc_sequencer_if;
    import exc_pkg::*;

    logic                insn_boundary;
    logic                syscall_req;
    logic                break_req;
    logic                teq_req;
    logic                eret_req;
    logic                ext_intr;
    logic [XLEN-1:0]     cur_pc;
    logic [XLEN-1:0]     cp0_status;
    logic [XLEN-1:0]     cp0_exc_addr;

    logic                cp0_exception;
    logic                cp0_eret;
    logic [CAUSE_W-1:0]  cp0_cause;
    logic [XLEN-1:0]     cp0_pc;
    logic                pc_load;
    logic [XLEN-1:0]     pc_next;
    logic                stall;

    modport master (
        input  insn_boundary, syscall_req, break_req, teq_req, eret_req, ext_intr,
        input  cur_pc, cp0_status, cp0_exc_addr,
        output cp0_exception, cp0_eret, cp0_cause, cp0_pc, pc_load, pc_next, stall
    );

    modport slave (
        output insn_boundary, syscall_req, break_req, teq_req, eret_req, ext_intr,
        output cur_pc, cp0_status, cp0_exc_addr,
        input  cp0_exception, cp0_eret, cp0_cause, cp0_pc, pc_load, pc_next, stall
    );

endinterface

// File: rtl/exc_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module exc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// CP0 exception initiator: prioritises traps/eret/interrupt and runs the strobe/redirect sequence.
// Build option: define EXC_SEQ_INTR_EN to enable the synchronised external interrupt path.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     INT_EN_BIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    exc_sequencer_if.master bus
);

    exc_state_t state;
    exc_rec_t   rec;
    logic       exc_q;
    logic       eret_q;
    logic       pc_load_q;
    logic       intr_sync;

`ifdef EXC_SEQ_INTR_EN
    exc_sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (bus.ext_intr),
        .q   (intr_sync)
    );
`else
    assign intr_sync = 1'b0;
    logic unused_ext_intr;
    assign unused_ext_intr = bus.ext_intr;
`endif

    // Only bit 0 and the enable bit of status matter here
    logic unused_status;
    assign unused_status = ^bus.cp0_status;

    logic trap_req;
    logic intr_ok;
    logic in_idle;

    assign trap_req = bus.syscall_req | bus.break_req | bus.teq_req;
    assign in_idle  = (state == ST_IDLE);
    assign intr_ok  = bus.insn_boundary & ~trap_req & ~bus.eret_req & intr_sync
                    & bus.cp0_status[0] & bus.cp0_status[INT_EN_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rec       <= '0;
            exc_q     <= 1'b0;
            eret_q    <= 1'b0;
            pc_load_q <= 1'b0;
        end else begin
            exc_q     <= 1'b0;
            eret_q    <= 1'b0;
            pc_load_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trap_req) begin
                        state     <= ST_RAISE;
                        exc_q     <= 1'b1;
                        rec.cause <= pick_cause(bus.syscall_req, bus.break_req);
                        rec.pc    <= bus.cur_pc;
                    end else if (bus.eret_req) begin
                        state  <= ST_ERET;
                        eret_q <= 1'b1;
                    end else if (intr_ok) begin
                        state     <= ST_RAISE;
                        exc_q     <= 1'b1;
                        rec.cause <= CAUSE_INTR;
                        rec.pc    <= bus.cur_pc;
                    end
                end
                ST_RAISE, ST_ERET: begin
                    state     <= ST_REDIRECT;
                    pc_load_q <= 1'b1;
                end
                ST_REDIRECT: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cp0_exception = exc_q;
    assign bus.cp0_eret      = eret_q;
    assign bus.cp0_cause     = rec.cause;
    assign bus.cp0_pc        = rec.pc;
    assign bus.pc_load       = pc_load_q;

    // exc_addr is only valid after the RAISE/ERET edge, so it is muxed rather than captured
    assign bus.pc_next = (state == ST_REDIRECT) ? bus.cp0_exc_addr : RESET_PC;
    assign bus.stall   = ~in_idle | trap_req | bus.eret_req | intr_ok;

    // A stalled control FSM must not issue new trap/eret pulses
    a_no_req_busy : assert property (@(posedge clk) disable iff (rst)
        !in_idle |-> !(trap_req | bus.eret_req));

endmodule
